// File: rtl/stream_widener.sv
// stream_widener: packs RATIO narrow beats LSB-first into one wide word, with FLUSH for partial words.
module stream_widener #(
    parameter int DIN_WIDTH = 128,
    parameter int RATIO     = 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         iVALID,
    output logic                         oREADY,
    input  logic [DIN_WIDTH-1:0]         DIN,
    input  logic                         FLUSH,
    output logic                         oVALID,
    input  logic                         iREADY,
    output logic [DIN_WIDTH*RATIO-1:0]   DOUT,
    output logic [RATIO-1:0]             oKEEP,
    output logic [31:0]                  oWORDS
);
    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
    logic [CW-1:0] fcnt;
    logic flush_pend;
    logic [RATIO-2:0][DIN_WIDTH-1:0] acc;
    logic [RATIO-1:0][DIN_WIDTH-1:0] word;
    logic [RATIO-1:0] keep;
    logic [CW:0] n;
    logic out_free, accept, flush_req, load;
    assign out_free  = !oVALID || iREADY;
    assign oREADY    = !RESET && !flush_pend && (fcnt != LAST || out_free);
    assign accept    = iVALID && oREADY;
    assign flush_req = FLUSH && !flush_pend && (fcnt != '0 || accept);
    assign load      = out_free && (flush_pend || flush_req || (accept && fcnt == LAST));
    assign n         = {1'b0, fcnt} + (CW + 1)'(accept);
    // Candidate word: filled slots, plus this cycle's beat in slot fcnt, zeros above.
    for (genvar k = 0; k < RATIO; k++) begin : g_slot
        if (k < RATIO - 1) begin : g_acc
            assign word[k] = ((CW + 1)'(k) < {1'b0, fcnt}) ? acc[k] :
                             (((CW + 1)'(k) == {1'b0, fcnt}) && accept) ? DIN : '0;
        end else begin : g_top
            assign word[k] = (accept && fcnt == LAST) ? DIN : '0;
        end
        assign keep[k] = (CW + 1)'(k) < n;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fcnt       <= '0;
            flush_pend <= 1'b0;
            acc        <= '0;
            oVALID     <= 1'b0;
            DOUT       <= '0;
            oKEEP      <= '0;
            oWORDS     <= '0;
        end else begin
            if (oVALID && iREADY) oWORDS <= oWORDS + 32'd1;
            if (load) begin
                DOUT       <= word;
                oKEEP      <= keep;
                oVALID     <= 1'b1;
                fcnt       <= '0;
                flush_pend <= 1'b0;
            end else begin
                if (iREADY) oVALID <= 1'b0;
                if (accept) fcnt <= fcnt + CW'(1);
                for (int k = 0; k < RATIO - 1; k++)
                    if (accept && fcnt == CW'(k)) acc[k] <= DIN;
                if (flush_req) flush_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_widener.sv
// tb_stream_widener: directed table, corner sequences and randomized traffic against a queue-based model.
module tb_stream_widener;
    localparam int W = 8;
    localparam int R = 4;
    logic CLK = 1'b0, RESET = 1'b1, iVALID = 1'b0, FLUSH = 1'b0, iREADY = 1'b0;
    logic [W-1:0] DIN = '0;
    logic oREADY, oVALID;
    logic [W*R-1:0] DOUT;
    logic [R-1:0] oKEEP;
    logic [31:0] oWORDS;
    stream_widener #(.DIN_WIDTH(W), .RATIO(R)) dut (
        .CLK(CLK), .RESET(RESET), .iVALID(iVALID), .oREADY(oREADY), .DIN(DIN),
        .FLUSH(FLUSH), .oVALID(oVALID), .iREADY(iREADY), .DOUT(DOUT),
        .oKEEP(oKEEP), .oWORDS(oWORDS)
    );
    always #5 CLK = ~CLK;
    int vecs = 0, errs = 0;
    bit [7:0] q[$];
    bit m_valid = 0, m_pend = 0, ordy_s;
    bit [31:0] m_data = 0, m_words = 0;
    bit [3:0] m_keep = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // One clock: drive, check oREADY before the edge, advance the model, check registered outputs after it.
    task automatic cycle(input bit rst, input bit v, input bit [7:0] d, input bit f, input bit r);
        bit ofree, rdy, frq;
        RESET = rst; iVALID = v; DIN = d; FLUSH = f; iREADY = r;
        #1;
        ofree = !m_valid || r;
        rdy = !rst && !m_pend && (q.size() != R - 1 || ofree);
        ordy_s = oREADY;
        chk("oREADY", 32'(oREADY), 32'(rdy));
        @(posedge CLK);
        if (rst) begin
            q.delete(); m_valid = 0; m_pend = 0; m_data = 0; m_keep = 0; m_words = 0;
        end else begin
            if (m_valid && r) m_words++;
            if (v && rdy) q.push_back(d);
            frq = f && !m_pend && q.size() > 0;
            if (ofree && (m_pend || frq || q.size() == R)) begin
                m_data = 0;
                foreach (q[k]) m_data |= 32'(q[k]) << (8 * k);
                m_keep = 4'((1 << q.size()) - 1);
                q.delete(); m_valid = 1; m_pend = 0;
            end else begin
                if (r) m_valid = 0;
                if (frq) m_pend = 1;
            end
        end
        #1;
        chk("oVALID", 32'(oVALID), 32'(m_valid));
        chk("DOUT", DOUT, m_data);
        chk("oKEEP", 32'(oKEEP), 32'(m_keep));
        chk("oWORDS", oWORDS, m_words);
    endtask
    typedef struct {
        bit v; bit [7:0] d; bit f; bit ordy; bit ov; bit [31:0] dout; bit [3:0] keep; bit [31:0] words;
    } vec_t;
    vec_t tbl[13];
    initial begin
        tbl = '{
            '{1, 8'h11, 0, 1, 0, 32'h0, 4'h0, 0},
            '{1, 8'h22, 0, 1, 0, 32'h0, 4'h0, 0},
            '{1, 8'h33, 0, 1, 0, 32'h0, 4'h0, 0},
            '{1, 8'h44, 0, 1, 1, 32'h44332211, 4'hF, 0},
            '{0, 8'h00, 0, 1, 0, 32'h44332211, 4'hF, 1},
            '{1, 8'hA1, 0, 1, 0, 32'h44332211, 4'hF, 1},
            '{1, 8'hA2, 0, 1, 0, 32'h44332211, 4'hF, 1},
            '{0, 8'h00, 1, 1, 1, 32'h0000A2A1, 4'h3, 1},
            '{0, 8'h00, 0, 1, 0, 32'h0000A2A1, 4'h3, 2},
            '{1, 8'hA1, 0, 1, 0, 32'h0000A2A1, 4'h3, 2},
            '{1, 8'hA2, 0, 1, 0, 32'h0000A2A1, 4'h3, 2},
            '{1, 8'hA3, 1, 1, 1, 32'h00A3A2A1, 4'h7, 2},
            '{0, 8'h00, 0, 1, 0, 32'h00A3A2A1, 4'h7, 3}
        };
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("rst_ordy", 32'(ordy_s), 32'd0);
        chk("rst_dout", DOUT, 32'd0);
        for (int i = 0; i < 13; i++) begin
            cycle(0, tbl[i].v, tbl[i].d, tbl[i].f, 1);
            chk("tbl_ordy", 32'(ordy_s), 32'(tbl[i].ordy));
            chk("tbl_ovalid", 32'(oVALID), 32'(tbl[i].ov));
            chk("tbl_dout", DOUT, tbl[i].dout);
            chk("tbl_keep", 32'(oKEEP), 32'(tbl[i].keep));
            chk("tbl_words", oWORDS, tbl[i].words);
        end
        // Stalled output with a full word held, then backpressure on the completing beat.
        cycle(0, 1, 8'h11, 0, 1); cycle(0, 1, 8'h22, 0, 1);
        cycle(0, 1, 8'h33, 0, 1); cycle(0, 1, 8'h44, 0, 1);
        cycle(0, 1, 8'h55, 0, 0); cycle(0, 1, 8'h66, 0, 0); cycle(0, 1, 8'h77, 0, 0);
        cycle(0, 1, 8'h88, 0, 0);
        chk("stall_ordy", 32'(ordy_s), 32'd0);
        chk("stall_hold", DOUT, 32'h44332211);
        chk("stall_ov", 32'(oVALID), 32'd1);
        cycle(0, 1, 8'h88, 0, 1);
        chk("release_ordy", 32'(ordy_s), 32'd1);
        chk("release_dout", DOUT, 32'h88776655);
        chk("release_words", oWORDS, 32'd4);
        // FLUSH while stalled sets the pending flag; a repeat FLUSH is absorbed.
        cycle(0, 1, 8'h99, 0, 0); cycle(0, 1, 8'hAA, 0, 0);
        cycle(0, 0, 8'h00, 1, 0);
        chk("pend_hold", DOUT, 32'h88776655);
        cycle(0, 1, 8'hBB, 0, 0);
        chk("pend_ordy", 32'(ordy_s), 32'd0);
        cycle(0, 0, 8'h00, 1, 0);
        cycle(0, 0, 8'h00, 0, 1);
        chk("pend_emit_ordy", 32'(ordy_s), 32'd0);
        chk("pend_dout", DOUT, 32'h0000AA99);
        chk("pend_keep", 32'(oKEEP), 32'h3);
        cycle(0, 0, 8'h00, 0, 1);
        chk("pend_after_ordy", 32'(ordy_s), 32'd1);
        chk("pend_no_second", 32'(oVALID), 32'd0);
        // Reset mid-word discards the partial word.
        cycle(0, 1, 8'h01, 0, 1); cycle(0, 1, 8'h02, 0, 1);
        cycle(1, 0, 8'h00, 0, 1);
        chk("midrst_ordy", 32'(ordy_s), 32'd0);
        chk("midrst_dout", DOUT, 32'd0);
        chk("midrst_words", oWORDS, 32'd0);
        cycle(0, 0, 8'h00, 0, 1); cycle(0, 0, 8'h00, 0, 1);
        chk("midrst_quiet", 32'(oVALID), 32'd0);
        cycle(0, 1, 8'h01, 0, 1); cycle(0, 1, 8'h02, 0, 1);
        cycle(0, 1, 8'h03, 0, 1); cycle(0, 1, 8'h04, 0, 1);
        chk("postrst_dout", DOUT, 32'h04030201);
        chk("postrst_keep", 32'(oKEEP), 32'hF);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, 8'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/stream_widener.md
STREAM_WIDENER -- requirements
Module: stream_widener

Interface
REQ-001 The block SHALL have parameter DIN_WIDTH, default 128, giving the input beat width in bits (legal range 8 to 512).
REQ-002 The block SHALL have parameter RATIO, default 2, giving the input beats packed per output word (legal range 2 to 16).
REQ-003 The block SHALL have port CLK, input, 1 bit: the clock; all logic is on the rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port iVALID, input, 1 bit: input beat valid.
REQ-006 The block SHALL have port oREADY, output, 1 bit: input beat accepted when iVALID and oREADY are both high.
REQ-007 The block SHALL have port DIN, input, DIN_WIDTH bits: input beat data.
REQ-008 The block SHALL have port FLUSH, input, 1 bit: single-cycle request to emit a partially filled word.
REQ-009 The block SHALL have port oVALID, output, 1 bit: output word valid.
REQ-010 The block SHALL have port iREADY, input, 1 bit: downstream accepts the output word when oVALID and iREADY are both high.
REQ-011 The block SHALL have port DOUT, output, DIN_WIDTH*RATIO bits: packed output word.
REQ-012 The block SHALL have port oKEEP, output, RATIO bits: bit k high means slot k of DOUT holds a real beat.
REQ-013 The block SHALL have port oWORDS, output, 32 bits: count of output words transferred since reset.

Function
REQ-014 Packing SHALL be LSB-first: the first accepted beat of a word goes to DOUT[DIN_WIDTH-1:0], beat k goes to slot k.
REQ-015 An accumulator SHALL hold up to RATIO-1 beats plus a fill count fcnt in the range 0 to RATIO-1.
REQ-016 A single output register SHALL drive DOUT, oKEEP and oVALID; its free condition is out_free = !oVALID or iREADY.
REQ-017 On an accepted beat with fcnt < RATIO-1, the block SHALL write the beat to slot fcnt and increment fcnt.
REQ-018 On an accepted beat with fcnt == RATIO-1, the block SHALL load the output register with the accumulator slots plus this beat, set oKEEP to all ones, set oVALID, and reset fcnt to 0.
REQ-019 Latency from the completing input beat to oVALID SHALL be 1 cycle.
REQ-020 oREADY SHALL equal !RESET and !flush_pend and (fcnt != RATIO-1 or out_free); the combinational path from iREADY to oREADY is permitted.
REQ-021 FLUSH with fcnt == 0 and no beat accepted that cycle SHALL be ignored.
REQ-022 FLUSH with fcnt > 0 or a beat accepted that cycle SHALL emit a word holding all filled slots, including a same-cycle beat.
REQ-023 In a flushed word, oKEEP SHALL have its lowest n bits set, where n is the slot count; unfilled DOUT slots SHALL be zero.
REQ-024 A FLUSH that completes a full word SHALL be identical to a normal full word (oKEEP all ones).
REQ-025 If the emit required by FLUSH cannot load because out_free is low, the block SHALL set flush_pend, hold oREADY low, and emit on the first cycle out_free is high.
REQ-026 A FLUSH arriving while flush_pend is already set SHALL be absorbed; it SHALL NOT cause a second emit.
REQ-027 When out_free is high and no new word loads, oVALID SHALL clear on the transfer cycle.
REQ-028 DOUT and oKEEP SHALL hold stable while oVALID is high and iREADY is low.
REQ-029 oWORDS SHALL increment on each cycle where oVALID and iREADY are both high, and SHALL wrap from 2^32-1 to 0.
REQ-030 A beat presented while oREADY is low SHALL NOT be accepted, and DIN SHALL be ignored in that cycle.

Reset
REQ-031 While RESET is high, the block SHALL drive oVALID=0, oREADY=0, DOUT=0, oKEEP=0, oWORDS=0, and clear fcnt, flush_pend and all accumulator slots.
REQ-032 An assertion of RESET mid-word SHALL discard the partial word and the pending output, and no word SHALL be emitted after RESET deasserts.
REQ-033 The first beat after RESET deasserts SHALL land in slot 0.

Verification (DIN_WIDTH=8, RATIO=4)
REQ-034 Bench: beats 0x11,0x22,0x33,0x44 on consecutive cycles with iREADY=1 -> next cycle DOUT=0x44332211, oKEEP=0xF, oVALID=1 for 1 cycle, oWORDS=1.
REQ-035 Bench: beats 0xA1,0xA2, then FLUSH alone -> DOUT=0x0000A2A1, oKEEP=0x3.
REQ-036 Bench: beats 0xA1,0xA2,0xA3 with FLUSH in the 0xA3 cycle -> DOUT=0x00A3A2A1, oKEEP=0x7.
REQ-037 Bench: iREADY=0 with a full word held, then 3 more beats plus a 4th offered -> oREADY=0 on the 4th beat, DOUT stays 0x44332211; raise iREADY -> 4th beat accepted the same cycle and the new word appears the next cycle.
REQ-038 Bench: FLUSH with fcnt=2 while the output is stalled -> flush_pend set and oREADY=0; release iREADY -> partial word with oKEEP=0x3, then oREADY=1.
REQ-039 Bench: RESET asserted after 2 beats -> all outputs 0; then 4 beats 0x01..0x04 -> DOUT=0x04030201.
